if_fetch: RTL
=============

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage. Owns the PC, fetches one 32-bit instruction as 4 byte reads over the shared
//  byte-wide memory port, and drives if_pc/if_inst to the IF/ID pipeline register. Requests a pipeline
//  stall while a fetch is in flight. Accepts branch redirects from later stages.
// PARAMETERS
//  RESET_PC   32'h0  PC loaded on reset
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   asynchronous reset, active-low (0 = reset)
//  stall_sign     in   6   ctrl stall vector; bit0 = hold PC/IF, bit1 = hold IF/ID
//  branch_en      in   1   redirect request, single-cycle pulse
//  branch_target  in   32  redirect PC
//  mem_req        out  1   byte read request
//  mem_addr       out  32  byte address of request
//  mem_gnt        in   1   arbiter accepts mem_req this cycle
//  mem_rdata      in   8   read byte, valid exactly 1 cycle after accepted request
//  if_stall_req   out  1   fetch in progress; ctrl must stall IF/ID
//  if_pc          out  32  PC of presented instruction
//  if_inst        out  32  presented instruction; 32'h0 when none ready
// BEHAVIOUR
//  Reset (rst=0, async): pc=RESET_PC, state=IDLE, byte_cnt=0, inst_buf=0; outputs mem_req=0,
//   mem_addr=RESET_PC, if_stall_req=1, if_pc=RESET_PC, if_inst=0.
//  States: IDLE, ISSUE, WAIT, DONE.
//   IDLE : mem_req=0. Next: ISSUE (unconditional, 1 cycle).
//   ISSUE: mem_req=1, mem_addr=pc+byte_cnt. mem_gnt=1 -> WAIT; else stay, addr held stable.
//   WAIT : mem_req=0; capture mem_rdata into inst_buf[8*byte_cnt+:8] (little-endian).
//          byte_cnt<3 -> byte_cnt+1, ISSUE. byte_cnt==3 -> byte_cnt=0, DONE.
//   DONE : if_inst=inst_buf, if_pc=pc, if_stall_req=0. stall_sign[0]=0 -> pc<=pc+4, ISSUE;
//          stall_sign[0]=1 -> stay in DONE, outputs held.
//  Outside DONE: if_inst=32'h0, if_pc=pc, if_stall_req=1.
//  Latency: 8 cycles ISSUE->DONE with mem_gnt held 1; each cycle mem_gnt=0 in ISSUE adds 1.
//  Branch: branch_en=1 in any state overrides all else: pc<=branch_target, byte_cnt=0, next=ISSUE.
//   Byte returning from an aborted request (branch in WAIT) is discarded, never written to inst_buf.
//   branch_en together with mem_gnt in ISSUE: request counts as aborted, its data ignored.
//   branch_en in DONE with stall_sign[0]=1: branch still taken.
//  PC arithmetic mod 2^32; pc+4 and pc+byte_cnt wrap at 32'hFFFF_FFFF. No alignment check.
//  stall_sign affects only DONE; ISSUE/WAIT progress regardless of stall_sign.
//  Reset mid-fetch: immediate return to reset values; partial inst_buf cleared.
// TESTING
//  1 Reset release, mem bytes @0 = 13 05 10 00, gnt=1 -> mem_addr 0,1,2,3; DONE on 10th cycle
//    after release, if_inst=32'h00100513, if_pc=0, if_stall_req=0.
//  2 Same, gnt=0 for 3 cycles on byte 2 -> mem_addr held =2, DONE 3 cycles later, same if_inst.
//  3 In DONE, stall_sign=6'b000011 for 5 cycles -> if_pc/if_inst held, no mem_req; release ->
//    next ISSUE with mem_addr=4.
//  4 branch_en with target 32'h100 while in WAIT of byte 1 -> next cycle ISSUE, mem_addr=32'h100;
//    stale byte ignored; if_inst = word @0x100.
//  5 pc=32'hFFFF_FFFC fetch complete, stall released -> pc wraps to 0, mem_addr=0.
//  6 rst asserted while in WAIT -> outputs at reset values same cycle (async); refetch from RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles one 32-bit instruction from four byte reads on the
// shared memory port and presents it with its PC to the IF/ID register.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall_sign,
   input  logic        branch_en,
   input  logic [31:0] branch_target,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic [7:0]  mem_rdata,
   output logic        if_stall_req,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_r;
   logic [31:0] pc_r;
   logic [1:0]  byte_cnt_r;
   logic [31:0] inst_buf_r;

   // IF/ID hold is applied by the pipeline register itself, not here.
   logic        stall_unused_s;
   assign stall_unused_s = ^stall_sign[5:1];

   // Fetch sequencer; outputs are registered alongside the state they describe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         pc_r         <= RESET_PC;
         byte_cnt_r   <= 2'd0;
         inst_buf_r   <= 32'h0000_0000;
         mem_req      <= 1'b0;
         mem_addr     <= RESET_PC;
         if_stall_req <= 1'b1;
         if_pc        <= RESET_PC;
         if_inst      <= 32'h0000_0000;
      end else if (branch_en) begin
         // Redirect wins over everything, including a grant or a returning byte.
         state_r      <= ISSUE;
         pc_r         <= branch_target;
         byte_cnt_r   <= 2'd0;
         mem_req      <= 1'b1;
         mem_addr     <= branch_target;
         if_stall_req <= 1'b1;
         if_pc        <= branch_target;
         if_inst      <= 32'h0000_0000;
      end else begin
         case (state_r)
            IDLE: begin
               state_r  <= ISSUE;
               mem_req  <= 1'b1;
               mem_addr <= pc_r + {30'd0, byte_cnt_r};
            end
            ISSUE: begin
               if (mem_gnt) begin
                  state_r <= WAIT;
                  mem_req <= 1'b0;
               end else begin
                  state_r <= ISSUE;
               end
            end
            WAIT: begin
               inst_buf_r[{byte_cnt_r, 3'b000} +: 8] <= mem_rdata;
               if (byte_cnt_r == 2'd3) begin
                  state_r      <= DONE;
                  byte_cnt_r   <= 2'd0;
                  if_inst      <= {mem_rdata, inst_buf_r[23:0]};
                  if_pc        <= pc_r;
                  if_stall_req <= 1'b0;
               end else begin
                  state_r    <= ISSUE;
                  byte_cnt_r <= byte_cnt_r + 2'd1;
                  mem_req    <= 1'b1;
                  mem_addr   <= pc_r + {30'd0, byte_cnt_r + 2'd1};
               end
            end
            DONE: begin
               if (!stall_sign[0]) begin
                  state_r      <= ISSUE;
                  pc_r         <= pc_r + 32'd4;
                  mem_req      <= 1'b1;
                  mem_addr     <= pc_r + 32'd4;
                  if_pc        <= pc_r + 32'd4;
                  if_inst      <= 32'h0000_0000;
                  if_stall_req <= 1'b1;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r      <= IDLE;
               byte_cnt_r   <= 2'd0;
               mem_req      <= 1'b0;
               if_stall_req <= 1'b1;
               if_inst      <= 32'h0000_0000;
            end
         endcase
      end
   end

endmodule
